trigger_arbiter: RTL

TRIGGER_ARBITER -- requirements
Module: trigger_arbiter

---
 rtl/trigger_arbiter_if.sv | 34 +++
 rtl/trigger_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/trigger_arbiter_if.sv
// trigger_arbiter_if: bundles the requester handshake and the shared
// triggered-FSM status/control lines of trigger_arbiter.
//   master : drives req, fsm_active, fsm_done; observes the arbiter outputs
//   slave  : the arbiter itself
//   req        per-requester level request (held until ack or err)
//   fsm_active active status from the shared triggered FSM
//   fsm_done   done status from the shared triggered FSM
//   trigger    one-cycle start pulse to the shared FSM
//   grant      one-hot owner of the shared FSM, zero when idle
//   ack        one-hot one-cycle completion pulse
//   busy       arbiter not idle
//   err        one-cycle timeout-abort pulse
interface trigger_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic            fsm_active;
    logic            fsm_done;
    logic            trigger;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] ack;
    logic            busy;
    logic            err;

    modport master (
        output req, fsm_active, fsm_done,
        input  trigger, grant, ack, busy, err
    );

    modport slave (
        input  req, fsm_active, fsm_done,
        output trigger, grant, ack, busy, err
    );
endinterface

// File: rtl/trigger_arbiter.sv
// trigger_arbiter: round-robin arbiter that hands one shared triggered FSM to
// one of NREQ requesters at a time, fires its start pulse, waits for it to
// finish and acknowledges the owner.
//   clk    single clock, rising edge
//   reset  synchronous, active-high
//   bus    trigger_arbiter_if.slave (req/fsm_active/fsm_done in,
//          trigger/grant/ack/busy/err out); all outputs are registered.
// Optional feature: define TRIG_ARB_TIMEOUT_EN to abort a transaction with a
// one-cycle err pulse when fsm_done has not arrived within TIMEOUT cycles of
// the trigger; without it the arbiter waits indefinitely and err is tied 0.
module trigger_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int NREQ    = 4
) (
    input logic              clk,
    input logic              reset,
    trigger_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FIRE      = 3'd1;
    localparam logic [2:0] S_WAIT_ACT  = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_RELEASE   = 3'd4;

    logic [2:0]      state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   pick;
    logic            trigger_q;
    logic            busy_q;
    logic [NREQ-1:0] grant_q;
    logic [NREQ-1:0] ack_q;

    // Round-robin pick: lowest offset from ptr wins. Scanning offsets from
    // high to low lets the nearest one overwrite the result last. Index
    // arithmetic wraps naturally because NREQ is a power of two.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IW-1:0]   p);
        logic [IW-1:0] idx;
        rr_pick = p;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = p + IW'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    assign pick = rr_pick(bus.req, ptr);

`ifdef TRIG_ARB_TIMEOUT_EN
    // cnt equals the number of cycles since the FIRE cycle; the abort is
    // scheduled one cycle early so err lands exactly TIMEOUT cycles after FIRE.
    logic [7:0] cnt;
    logic       err_q;
    logic       expired;
    assign expired = (cnt + 8'd1) == 8'(TIMEOUT);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            owner     <= '0;
            trigger_q <= 1'b0;
            grant_q   <= '0;
            ack_q     <= '0;
            busy_q    <= 1'b0;
`ifdef TRIG_ARB_TIMEOUT_EN
            cnt       <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            trigger_q <= 1'b0;
            ack_q     <= '0;
`ifdef TRIG_ARB_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (|bus.req) begin
                        state     <= S_FIRE;
                        owner     <= pick;
                        grant_q   <= NREQ'(1) << pick;
                        trigger_q <= 1'b1;
                        busy_q    <= 1'b1;
`ifdef TRIG_ARB_TIMEOUT_EN
                        cnt       <= '0;
`endif
                    end
                end
                // FSM status is not looked at here: the FSM has not seen
                // the trigger yet, so anything on the lines is stale.
                S_FIRE: begin
                    state <= S_WAIT_ACT;
`ifdef TRIG_ARB_TIMEOUT_EN
                    cnt   <= cnt + 8'd1;
`endif
                end
                // done wins over active and over the timeout, so a fast FSM
                // can skip WAIT_DONE entirely.
                S_WAIT_ACT, S_WAIT_DONE: begin
                    if (bus.fsm_done) begin
                        state <= S_RELEASE;
                        ack_q <= grant_q;
                    end
`ifdef TRIG_ARB_TIMEOUT_EN
                    else if (expired) begin
                        state   <= S_IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        ptr     <= owner + IW'(1);
                    end
`endif
                    else if (state == S_WAIT_ACT && bus.fsm_active) begin
                        state <= S_WAIT_DONE;
                    end
`ifdef TRIG_ARB_TIMEOUT_EN
                    cnt <= cnt + 8'd1;
`endif
                end
                // grant is held through this cycle alongside ack and dropped
                // on the way out, which also blocks a back-to-back grant.
                S_RELEASE: begin
                    state   <= S_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    ptr     <= owner + IW'(1);
                end
                default: begin
                    state   <= S_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trigger = trigger_q;
    assign bus.grant   = grant_q;
    assign bus.ack     = ack_q;
    assign bus.busy    = busy_q;
`ifdef TRIG_ARB_TIMEOUT_EN
    assign bus.err     = err_q;
`else
    assign bus.err     = 1'b0;
`endif

endmodule
